// File: rtl/invaders_pkg.sv
// Shared fleet geometry, scoring table and hit-detect FSM state type.
package invaders_pkg;

    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 8;
    localparam int unsigned ALIEN_W   = 24;
    localparam int unsigned ALIEN_H   = 16;
    localparam int unsigned COL_PITCH = 40;
    localparam int unsigned ROW_PITCH = 32;

    // Box math is one bit wider than screen coords so fleet offsets never wrap.
    localparam int unsigned COORD_W   = 11;
    localparam int unsigned ROW_IW    = $clog2(ROWS);
    localparam int unsigned SCORE_W   = 10;

    localparam logic [SCORE_W-1:0] ROW_POINTS [ROWS] = '{10'd30, 10'd20, 10'd20, 10'd10};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2,
        REFILL = 2'd3
    } state_t;

    function automatic logic [SCORE_W-1:0] row_points(input logic [ROW_IW-1:0] row);
        return ROW_POINTS[row];
    endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// Point-in-box overlap test: half-open on the right and bottom edges.
module hit_box_cmp #(
    parameter int unsigned W = 11
) (
    input  logic [W-1:0] box_x,
    input  logic [W-1:0] box_y,
    input  logic [W-1:0] box_w,
    input  logic [W-1:0] box_h,
    input  logic [W-1:0] pt_x,
    input  logic [W-1:0] pt_y,
    output logic         hit
);

    logic [W-1:0] box_x_end;
    logic [W-1:0] box_y_end;

    assign box_x_end = box_x + box_w;
    assign box_y_end = box_y + box_h;

    assign hit = (pt_x >= box_x) && (pt_x < box_x_end) &&
                 (pt_y >= box_y) && (pt_y < box_y_end);

endmodule

// File: rtl/alien_hit_detect.sv
// Serial projectile-vs-fleet collision scan: one alien per cycle, first hit wins,
// kills the alien, scores it, and refills the fleet when the wave is cleared.
module alien_hit_detect #(
    parameter int unsigned ROWS      = invaders_pkg::ROWS,
    parameter int unsigned COLS      = invaders_pkg::COLS,
    parameter int unsigned ALIEN_W   = invaders_pkg::ALIEN_W,
    parameter int unsigned ALIEN_H   = invaders_pkg::ALIEN_H,
    parameter int unsigned COL_PITCH = invaders_pkg::COL_PITCH,
    parameter int unsigned ROW_PITCH = invaders_pkg::ROW_PITCH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 proj_tick,
    input  logic                 proj_active,
    input  logic [9:0]           proj_xcoord,
    input  logic [9:0]           proj_ycoord,
    input  logic [9:0]           fleet_xcoord,
    input  logic [9:0]           fleet_ycoord,
    output logic [ROWS*COLS-1:0] alive,
    output logic                 hit_pulse,
    output logic                 proj_kill,
    output logic [9:0]           score,
    output logic                 wave_clear,
    output logic                 busy
);

    import invaders_pkg::*;

    localparam int unsigned N        = ROWS * COLS;
    localparam int unsigned IW       = $clog2(N);
    localparam int unsigned CW       = COORD_W;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [10:0]   SCORE_MAX = 11'd1023;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [9:0]    px_q, px_d, py_q, py_d, fx_q, fx_d, fy_q, fy_d;
    logic          cmp_valid_q, cmp_valid_d;
    logic          hit_q, hit_d;
    logic          last_q, last_d;
    logic [IW-1:0] hit_idx_q, hit_idx_d;
    logic [N-1:0]  alive_d;
    logic [9:0]    score_d;
    logic          hit_pulse_d, proj_kill_d, wave_clear_d, busy_d;

    logic [IW-1:0] col_c, row_c;
    logic [CW-1:0] box_x_c, box_y_c;
    logic          box_hit_c, hit_c;
    logic          start_c, kill_c;
    logic [N-1:0]  alive_after_c;
    logic [9:0]    pts_c;
    logic [10:0]   score_sum_c;

    // Origin of the alien under test, computed from the latched fleet position.
    assign col_c   = IW'(idx_q % COLS);
    assign row_c   = IW'(idx_q / COLS);
    assign box_x_c = CW'(fx_q) + CW'(col_c) * CW'(COL_PITCH);
    assign box_y_c = CW'(fy_q) + CW'(row_c) * CW'(ROW_PITCH);

    hit_box_cmp #(.W(CW)) u_hit_box_cmp (
        .box_x (box_x_c),
        .box_y (box_y_c),
        .box_w (CW'(ALIEN_W)),
        .box_h (CW'(ALIEN_H)),
        .pt_x  (CW'(px_q)),
        .pt_y  (CW'(py_q)),
        .hit   (box_hit_c)
    );

    assign hit_c         = box_hit_c && alive[idx_q];
    assign start_c       = (state_q == IDLE) && proj_tick && proj_active;
    assign kill_c        = (state_q == SCAN) && cmp_valid_q && hit_q;
    assign alive_after_c = alive & ~(N'(1) << hit_idx_q);
    assign pts_c         = row_points(ROW_IW'(hit_idx_q / COLS));
    assign score_sum_c   = 11'(score) + 11'(pts_c);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        px_d         = px_q;
        py_d         = py_q;
        fx_d         = fx_q;
        fy_d         = fy_q;
        cmp_valid_d  = cmp_valid_q;
        hit_d        = hit_q;
        last_d       = last_q;
        hit_idx_d    = hit_idx_q;
        alive_d      = alive;
        score_d      = score;
        hit_pulse_d  = 1'b0;
        proj_kill_d  = 1'b0;
        wave_clear_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d     = SCAN;
                    idx_d       = '0;
                    px_d        = proj_xcoord;
                    py_d        = proj_ycoord;
                    fx_d        = fleet_xcoord;
                    fy_d        = fleet_ycoord;
                    cmp_valid_d = 1'b0;
                    hit_d       = 1'b0;
                    last_d      = 1'b0;
                end
            end
            SCAN: begin
                // Compare result is registered; it is acted on one cycle later.
                cmp_valid_d = 1'b1;
                hit_d       = hit_c;
                hit_idx_d   = idx_q;
                last_d      = (idx_q == LAST_IDX);
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IW'(1);
                end
                if (kill_c) begin
                    state_d      = REPORT;
                    alive_d      = alive_after_c;
                    score_d      = (score_sum_c > SCORE_MAX) ? 10'(SCORE_MAX) : score_sum_c[9:0];
                    hit_pulse_d  = 1'b1;
                    proj_kill_d  = 1'b1;
                    wave_clear_d = (alive_after_c == '0);
                end else if (cmp_valid_q && last_q) begin
                    state_d = IDLE;
                end
            end
            REPORT: begin
                if (alive == '0) begin
                    state_d = REFILL;
                    alive_d = '1;
                end else begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
            cmp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            last_q      <= 1'b0;
            hit_idx_q   <= '0;
            alive       <= '1;
            score       <= '0;
            hit_pulse   <= 1'b0;
            proj_kill   <= 1'b0;
            wave_clear  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            px_q        <= px_d;
            py_q        <= py_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            cmp_valid_q <= cmp_valid_d;
            hit_q       <= hit_d;
            last_q      <= last_d;
            hit_idx_q   <= hit_idx_d;
            alive       <= alive_d;
            score       <= score_d;
            hit_pulse   <= hit_pulse_d;
            proj_kill   <= proj_kill_d;
            wave_clear  <= wave_clear_d;
            busy        <= busy_d;
        end
    end

endmodule
